// File: rtl/ir_cmd_scheduler.sv
// NEC IR command scheduler: filters decoded frames, queues them in a show-ahead FIFO,
// and (when IR_CMD_REPEAT_EN is defined) turns repeat codes into re-queued commands.
module ir_cmd_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_WINDOW = 2700000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          addr_filter_en,
  input  logic [7:0]                    addr_match,
  input  logic                          frame_valid,
  input  logic [7:0]                    frame_addr,
  input  logic [7:0]                    frame_data,
  input  logic                          frame_repeat,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [7:0]                    cmd_addr,
  output logic [7:0]                    cmd_data,
  output logic                          cmd_is_repeat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          dbg_repeat_armed
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rep;
  } entry_t;

  // Handshake: the head transfers on any rising edge where cmd_valid && cmd_ready.
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;

  logic               frame_acc, rep_hon, push_req, push, pop, full, drop;
  logic [7:0]         last_addr, last_data;
  entry_t             new_entry, head;

  assign frame_acc = enable && frame_valid && (!addr_filter_en || (frame_addr == addr_match));

`ifdef IR_CMD_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_WINDOW + 1);
  typedef enum logic {ST_IDLE, ST_ARMED} rep_state_t;

  rep_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_addr_q, last_addr_d, last_data_q, last_data_d;
  logic             armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (frame_acc) begin
      state_d     = ST_ARMED;
      cnt_d       = CNT_W'(REPEAT_WINDOW);
      last_addr_d = frame_addr;
      last_data_d = frame_data;
    end else if (rep_hon) begin
      cnt_d = CNT_W'(REPEAT_WINDOW);
    end else if (state_q == ST_ARMED) begin
      // The window closes on the edge where the count reaches zero.
      if (cnt_q <= CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    armed            = (state_q == ST_ARMED);
    rep_hon          = enable && frame_repeat && !frame_valid && armed;
    dbg_repeat_armed = armed;
  end

  assign last_addr     = last_addr_q;
  assign last_data     = last_data_q;
  assign cmd_is_repeat = cmd_valid && head.rep;
`else
  logic unused_ok;
  assign rep_hon          = 1'b0;
  assign last_addr        = '0;
  assign last_data        = '0;
  assign dbg_repeat_armed = 1'b0;
  assign cmd_is_repeat    = 1'b0;
  assign unused_ok        = ^{frame_repeat, 1'(REPEAT_WINDOW), head.rep};
`endif

  always_comb begin
    pop       = cmd_valid && cmd_ready;
    full      = (level_q == LVL_W'(FIFO_DEPTH));
    push_req  = frame_acc || rep_hon;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    new_entry = frame_acc ? '{addr: frame_addr, data: frame_data, rep: 1'b0}
                          : '{addr: last_addr,  data: last_data,  rep: 1'b1};
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head       = mem_q[rd_ptr_q];
  assign cmd_valid  = (level_q != '0);
  assign cmd_addr   = cmd_valid ? head.addr : 8'h00;
  assign cmd_data   = cmd_valid ? head.data : 8'h00;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
endmodule

// File: doc/ir_cmd_scheduler.md
IR_CMD_SCHEDULER -- requirements
Module: ir_cmd_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue entries; power of two, range 2..16.
REQ-002 Parameter REPEAT_WINDOW, default 2700000: cycles after the last frame during which a repeat code is honoured (108 ms at 25 MHz).
REQ-003 Port clk  in  1  single system clock; all state on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port enable  in  1  scheduler enable.
REQ-006 Port addr_filter_en  in  1  when high, only frames whose address equals addr_match are accepted.
REQ-007 Port addr_match  in  8  accepted NEC address.
REQ-008 Port frame_valid  in  1  one-cycle pulse from the NEC receiver: new frame decoded.
REQ-009 Port frame_addr  in  8  decoded address, valid with frame_valid.
REQ-010 Port frame_data  in  8  decoded command, valid with frame_valid.
REQ-011 Port frame_repeat  in  1  one-cycle pulse from the NEC receiver: repeat code decoded.
REQ-012 Port cmd_valid  out  1  queue head available.
REQ-013 Port cmd_ready  in  1  consumer accepts the head.
REQ-014 Port cmd_addr  out  8  head address.
REQ-015 Port cmd_data  out  8  head command.
REQ-016 Port cmd_is_repeat  out  1  head originated from a repeat code.
REQ-017 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
REQ-018 Port overflow  out  1  sticky flag: a command was dropped.
REQ-019 Port overflow_clr  in  1  clears overflow.

Function
REQ-020 Queue SHALL be show-ahead FIFO: cmd_valid = (fifo_level != 0); cmd_addr/cmd_data/cmd_is_repeat reflect head combinationally from registered storage.
REQ-021 Pop SHALL occur on clock edge where cmd_valid && cmd_ready; cmd_ready while empty has no effect.
REQ-022 Accepted frame SHALL be pushed on the edge where frame_valid is sampled; visible on cmd_valid the next cycle (1-cycle latency from empty).
REQ-023 Frame SHALL be accepted iff enable && frame_valid && (!addr_filter_en || frame_addr == addr_match); rejected frames leave state unchanged, including repeat state.
REQ-024 Full queue: push SHALL succeed if a pop occurs in the same cycle; otherwise the new command is dropped, queue unchanged, overflow set.
REQ-025 Simultaneous push and pop on non-full, non-empty queue: fifo_level unchanged, order preserved.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH and never underflows.
REQ-027 Repeat FSM states IDLE, ARMED; IDLE -> ARMED on accepted frame (last_addr/last_data latched, window counter loaded with REPEAT_WINDOW).
REQ-028 In ARMED, counter decrements each cycle; each accepted frame or honoured repeat reloads it; counter reaching 0 -> IDLE.
REQ-029 frame_repeat in ARMED with enable high SHALL push {last_addr, last_data, is_repeat=1} under the same full/overflow rules; in IDLE it is ignored.
REQ-030 frame_valid and frame_repeat in same cycle: frame_valid processed, frame_repeat ignored.
REQ-031 overflow_clr and a new drop in same cycle: overflow remains 1 (set wins).
REQ-032 enable low SHALL flush the queue (fifo_level=0 next cycle), force IDLE and ignore frame inputs; overflow retained.

Reset
REQ-033 rst_n low SHALL immediately force: cmd_valid 0, fifo_level 0, cmd_addr/cmd_data/cmd_is_repeat 0, overflow 0, FSM IDLE, window counter 0, pointers 0.
REQ-034 Reset mid-transfer SHALL discard all queued and latched commands; no partial entry survives.

Configuration
REQ-035 Macro IR_CMD_REPEAT_EN defined: repeat FSM and window counter per REQ-027..REQ-030 present.
REQ-036 IR_CMD_REPEAT_EN undefined: frame_repeat ignored, no FSM/counter logic, cmd_is_repeat tied 0, REPEAT_WINDOW unused; all other behaviour identical.

Verification
REQ-037 Frame addr 0x5A data 0x3C, filter off, cmd_ready 0 -> next cycle cmd_valid 1, cmd_addr 0x5A, cmd_data 0x3C, fifo_level 1; cmd_ready 1 -> cmd_valid 0.
REQ-038 Filter on, addr_match 0x10; frames addr 0x11 then 0x10 data 0x07 -> only 0x10/0x07 queued, fifo_level 1.
REQ-039 cmd_ready 0, five frames data 0x01..0x05 (depth 4) -> fifo_level 4, overflow 1, pops yield 0x01..0x04; overflow_clr -> overflow 0.
REQ-040 With IR_CMD_REPEAT_EN, REPEAT_WINDOW 100: frame data 0x22, repeat at cycle +50 -> second entry data 0x22 cmd_is_repeat 1; repeat at +200 after last event -> nothing queued.
REQ-041 Queue full, frame_valid and cmd_ready same cycle -> head popped, new frame at tail, fifo_level stays 4, overflow 0.
REQ-042 Two entries queued, rst_n pulsed low mid-cycle -> cmd_valid 0 and fifo_level 0 immediately, without waiting for clk.
